// File: rtl/corr_pkg.sv
// Shared constants and helpers for the MSDFT correlator chain.
package corr_pkg;

    // MSDFT bin component width and the resulting power width.
    localparam int unsigned BIN_WIDTH     = 16;
    localparam int unsigned POW_WIDTH     = 32;
    localparam int unsigned LEN_DEF_WIDTH = 16;

    // Ceiling log2, used at integration to size window-length fields.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pow_acc_ctrl_if.sv
// Sample-in / power-out bus between the MSDFT stage and the accumulator.
interface pow_acc_ctrl_if
    import corr_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = BIN_WIDTH,
    parameter int unsigned DOUT_WIDTH = POW_WIDTH,
    parameter int unsigned LEN_WIDTH  = LEN_DEF_WIDTH
);
    logic signed [DIN_WIDTH-1:0] din_re;
    logic signed [DIN_WIDTH-1:0] din_im;
    logic                        din_valid;
    logic [LEN_WIDTH-1:0]        acc_len;
    logic [DOUT_WIDTH-1:0]       dout;
    logic                        dout_valid;
    logic                        acc_done;
    logic [LEN_WIDTH-1:0]        win_count;

    // Producer side: drives bins and window length, observes the framed power.
    modport master (
        output din_re, din_im, din_valid, acc_len,
        input  dout, dout_valid, acc_done, win_count
    );

    // Block side.
    modport slave (
        input  din_re, din_im, din_valid, acc_len,
        output dout, dout_valid, acc_done, win_count
    );
endinterface

// File: rtl/pow_acc_ctrl_complex_pow.sv
// Three-stage |x|^2 pipeline: register inputs, square each component, sum.
module complex_pow
    import corr_pkg::*;
#(
    parameter int unsigned DIN_WIDTH = BIN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DIN_WIDTH-1:0]   din_re,
    input  logic signed [DIN_WIDTH-1:0]   din_im,
    input  logic                          din_valid,
    output logic [2*DIN_WIDTH-1:0]        pow,
    output logic                          pow_valid,
    output logic                          sq_valid
);
    localparam int unsigned PW = 2 * DIN_WIDTH;

    logic signed [DIN_WIDTH-1:0] s1_re;
    logic signed [DIN_WIDTH-1:0] s1_im;
    logic                        s1_valid;
    logic signed [PW-1:0]        sq_re;
    logic signed [PW-1:0]        sq_im;

    // Stage 1: capture the incoming bin; data only moves on valid cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_re <= din_re;
                s1_im <= din_im;
            end
        end
    end

    // Stage 2: signed squares, sign-extended so the full product is kept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sq_valid <= 1'b0;
            sq_re    <= '0;
            sq_im    <= '0;
        end else begin
            sq_valid <= s1_valid;
            if (s1_valid) begin
                sq_re <= PW'(s1_re) * PW'(s1_re);
                sq_im <= PW'(s1_im) * PW'(s1_im);
            end
        end
    end

    // Stage 3: unsigned sum; max 2^(PW-1) so it cannot wrap. Holds when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pow_valid <= 1'b0;
            pow       <= '0;
        end else begin
            pow_valid <= sq_valid;
            if (sq_valid) begin
                pow <= $unsigned(sq_re) + $unsigned(sq_im);
            end
        end
    end

endmodule

// File: rtl/pow_acc_ctrl.sv
// Power computation plus accumulator framing (acc_done / window index).
module pow_acc_ctrl
    import corr_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = BIN_WIDTH,
    parameter int unsigned DOUT_WIDTH = POW_WIDTH,
    parameter int unsigned LEN_WIDTH  = LEN_DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    pow_acc_ctrl_if.slave bus
);
    localparam int unsigned PW = 2 * DIN_WIDTH;

    logic [PW-1:0]        pow;
    logic                 pow_valid;
    logic                 sq_valid;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] len_eff_c;
    logic                 acc_done_q;
    logic [LEN_WIDTH-1:0] win_count_q;

    complex_pow #(
        .DIN_WIDTH (DIN_WIDTH)
    ) u_complex_pow (
        .clk       (clk),
        .rst       (rst),
        .din_re    (bus.din_re),
        .din_im    (bus.din_im),
        .din_valid (bus.din_valid),
        .pow       (pow),
        .pow_valid (pow_valid),
        .sq_valid  (sq_valid)
    );

    // A zero window length behaves as a one-sample window.
    always_comb begin
        len_eff_c = bus.acc_len;
        if (bus.acc_len == '0) begin
            len_eff_c = LEN_WIDTH'(1);
        end
    end

    // Window counter, updated on the same edge the power reaches the output.
    // cnt==0 marks a window start; reset leaves it there so the first output
    // after reset frames a fresh window. Length is latched only at a start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            len_r       <= LEN_WIDTH'(1);
            acc_done_q  <= 1'b0;
            win_count_q <= '0;
        end else begin
            acc_done_q <= 1'b0;
            if (sq_valid) begin
                win_count_q <= cnt;
                if (cnt == '0) begin
                    acc_done_q <= 1'b1;
                    len_r      <= len_eff_c;
                    if (len_eff_c == LEN_WIDTH'(1)) begin
                        cnt <= '0;
                    end else begin
                        cnt <= LEN_WIDTH'(1);
                    end
                end else if (cnt == LEN_WIDTH'(len_r - LEN_WIDTH'(1))) begin
                    cnt <= '0;
                end else begin
                    cnt <= LEN_WIDTH'(cnt + LEN_WIDTH'(1));
                end
            end
        end
    end

    // Outputs come straight from registers; power is zero-extended.
    assign bus.dout       = DOUT_WIDTH'(pow);
    assign bus.dout_valid = pow_valid;
    assign bus.acc_done   = acc_done_q;
    assign bus.win_count  = win_count_q;

endmodule

// File: tb/tb_pow_acc_ctrl.sv
// Self-checking bench for pow_acc_ctrl: directed tables, corner sequences, random run.
module tb_pow_acc_ctrl;
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 32;
    localparam int unsigned LW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pow_acc_ctrl_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .LEN_WIDTH(LW)) bus ();

    pow_acc_ctrl #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output = power of the input sampled two edges earlier;
    // windows are counted in valid outputs, length taken at each window start.
    bit                   h_v  [2] = '{1'b0, 1'b0};
    logic signed [DW-1:0] h_re [2] = '{16'sd0, 16'sd0};
    logic signed [DW-1:0] h_im [2] = '{16'sd0, 16'sd0};
    longint unsigned      ex_dout = 0;
    bit                   ex_v = 1'b0;
    bit                   ex_done = 1'b0;
    int                   ex_wc = 0;
    int                   remaining = 0;

    always @(posedge clk) begin
        if (!rst) begin
            h_v[0] = 1'b0; h_v[1] = 1'b0;
            ex_dout = 0; ex_v = 1'b0; ex_done = 1'b0; ex_wc = 0; remaining = 0;
        end else begin
            if (h_v[1]) begin
                ex_v = 1'b1;
                ex_dout = longint'(longint'(h_re[1]) * longint'(h_re[1]) +
                                   longint'(h_im[1]) * longint'(h_im[1]));
                if (remaining == 0) begin
                    ex_done = 1'b1;
                    ex_wc = 0;
                    remaining = ((bus.acc_len == 0) ? 1 : int'(bus.acc_len)) - 1;
                end else begin
                    ex_done = 1'b0;
                    ex_wc = ex_wc + 1;
                    remaining = remaining - 1;
                end
            end else begin
                ex_v = 1'b0;
                ex_done = 1'b0;
            end
            h_v[1] = h_v[0]; h_re[1] = h_re[0]; h_im[1] = h_im[0];
            h_v[0] = bus.din_valid; h_re[0] = bus.din_re; h_im[0] = bus.din_im;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_dout_valid", 64'(bus.dout_valid), 64'(ex_v));
            check("m_acc_done", 64'(bus.acc_done), 64'(ex_done));
            check("m_win_count", 64'(bus.win_count), 64'(ex_wc));
            check("m_dout", 64'(bus.dout), 64'(ex_dout));
            check("done_without_valid", 64'(bus.acc_done & ~bus.dout_valid), 64'(0));
        end
    end

    logic [OW-1:0] cap_dout [$];
    logic          cap_done [$];
    logic [LW-1:0] cap_wc   [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cap();
        step();
        if (bus.dout_valid) begin
            cap_dout.push_back(bus.dout);
            cap_done.push_back(bus.acc_done);
            cap_wc.push_back(bus.win_count);
        end
    endtask

    task automatic clear_cap();
        cap_dout.delete();
        cap_done.delete();
        cap_wc.delete();
    endtask

    task automatic drive(input bit v, input int re, input int im);
        bus.din_valid = v;
        bus.din_re = DW'(re);
        bus.din_im = DW'(im);
    endtask

    task automatic do_reset();
        bus.din_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        int            re;
        int            im;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t tbl [8];
    bit   vld3 [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    int   wc4 [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    int   wc3 [7]  = '{0, 1, 2, 0, 1, 2, 0};
    bit   done_chg [20] = '{1,0,0,0, 1,0, 1,0, 1,0, 1,0, 1,0, 1,1,1,1,1,1};

    initial begin
        rst = 1'b0;
        bus.din_valid = 1'b0;
        bus.din_re = '0;
        bus.din_im = '0;
        bus.acc_len = LW'(1);

        tbl[0] = '{3, -4, 32'd25};
        tbl[1] = '{-32768, -32768, 32'h8000_0000};
        tbl[2] = '{32767, -32768, 32'h7FFF_0001};
        tbl[3] = '{0, 0, 32'd0};
        tbl[4] = '{1, 1, 32'd2};
        tbl[5] = '{-1, 0, 32'd1};
        tbl[6] = '{100, -100, 32'd20000};
        tbl[7] = '{32767, 32767, 32'h7FFE_0002};

        // Reset state.
        step();
        check("rst_dout", 64'(bus.dout), 64'(0));
        check("rst_dout_valid", 64'(bus.dout_valid), 64'(0));
        check("rst_acc_done", 64'(bus.acc_done), 64'(0));
        check("rst_win_count", 64'(bus.win_count), 64'(0));
        rst = 1'b1;
        chk_en = 1'b1;

        // Single isolated samples, 3-cycle latency, one-sample windows.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].re, tbl[i].im);
            step();
            bus.din_valid = 1'b0;
            step();
            step();
            check("vec_dout", 64'(bus.dout), 64'(tbl[i].exp));
            check("vec_valid", 64'(bus.dout_valid), 64'(1));
            check("vec_done", 64'(bus.acc_done), 64'(1));
            check("vec_wc", 64'(bus.win_count), 64'(0));
        end

        // acc_len=4, ten back-to-back samples.
        do_reset();
        bus.acc_len = LW'(4);
        clear_cap();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1, 1);
            tick_cap();
        end
        bus.din_valid = 1'b0;
        repeat (4) tick_cap();
        check("len4_count", 64'(cap_dout.size()), 64'(10));
        for (int k = 0; k < 10 && k < cap_dout.size(); k++) begin
            check("len4_dout", 64'(cap_dout[k]), 64'(2));
            check("len4_wc", 64'(cap_wc[k]), 64'(wc4[k]));
            check("len4_done", 64'(cap_done[k]), 64'(k % 4 == 0));
        end

        // acc_len=3 with a two-cycle bubble after sample 1.
        do_reset();
        bus.acc_len = LW'(3);
        clear_cap();
        for (int k = 0; k < 11; k++) begin
            drive(vld3[k], k, -k);
            tick_cap();
        end
        repeat (4) tick_cap();
        check("bub_count", 64'(cap_dout.size()), 64'(7));
        for (int k = 0; k < 7 && k < cap_dout.size(); k++) begin
            check("bub_wc", 64'(cap_wc[k]), 64'(wc3[k]));
            check("bub_done", 64'(cap_done[k]), 64'(k % 3 == 0));
        end

        // Length changes 4 -> 2 mid-window, then 0.
        do_reset();
        clear_cap();
        for (int k = 0; k < 20; k++) begin
            bus.acc_len = (k < 5) ? LW'(4) : (k < 15) ? LW'(2) : LW'(0);
            drive(1'b1, 2, 3);
            tick_cap();
        end
        bus.din_valid = 1'b0;
        repeat (4) tick_cap();
        check("chg_count", 64'(cap_done.size()), 64'(20));
        for (int k = 0; k < 20 && k < cap_done.size(); k++) begin
            check("chg_done", 64'(cap_done[k]), 64'(done_chg[k]));
            check("chg_dout", 64'(cap_dout[k]), 64'(13));
        end

        // Reset mid-window with samples in flight, plus a sample at the reset edge.
        do_reset();
        bus.acc_len = LW'(4);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1, 1);
            step();
        end
        drive(1'b1, 7, 7);
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.din_valid = 1'b0;
        clear_cap();
        repeat (3) tick_cap();
        check("rstmid_flushed", 64'(cap_dout.size()), 64'(0));
        drive(1'b1, 2, 0);
        tick_cap();
        bus.din_valid = 1'b0;
        tick_cap();
        tick_cap();
        check("rstmid_count", 64'(cap_dout.size()), 64'(1));
        if (cap_dout.size() > 0) begin
            check("rstmid_dout", 64'(cap_dout[0]), 64'(4));
            check("rstmid_done", 64'(cap_done[0]), 64'(1));
            check("rstmid_wc", 64'(cap_wc[0]), 64'(0));
        end

        // Randomized run against the model.
        bus.acc_len = LW'($urandom_range(0, 5));
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                bus.acc_len = LW'($urandom_range(0, 5));
            end
            rst = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
            step();
        end
        rst = 1'b1;
        bus.din_valid = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pow_acc_ctrl.md
Name: pow_acc_ctrl

Overview:
- Stage directly upstream of the unsigned accumulator in the MSDFT correlator chain.
- Takes one signed complex MSDFT bin per valid cycle and computes its power, re^2 + im^2, as an unsigned value.
- Generates the accumulator framing: dout_valid and an acc_done pulse on the first sample of every window of acc_len samples.
- Output is cycle-aligned for direct connection to the accumulator's din / din_valid / acc_done inputs.

Parameters:
- DIN_WIDTH, 16, width of each signed input component.
- DOUT_WIDTH, 32, unsigned power width; must be >= 2*DIN_WIDTH; result is zero-extended.
- LEN_WIDTH, 16, width of the acc_len window-length input.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- din_re  input  DIN_WIDTH  signed real part.
- din_im  input  DIN_WIDTH  signed imaginary part.
- din_valid  input  1  qualifies din_re/din_im.
- acc_len  input  LEN_WIDTH  samples per accumulation window; value 0 is treated as 1.
- dout  output  DOUT_WIDTH  unsigned power.
- dout_valid  output  1  qualifies dout.
- acc_done  output  1  high with dout_valid on the first sample of each window.
- win_count  output  LEN_WIDTH  index of the current sample within its window (debug/verification).

Behaviour:
- Reset (rst=0 at a clock edge):
  - All pipeline valids clear.
  - dout=0, dout_valid=0, acc_done=0, win_count=0.
  - Window counter clears; first_pending sets.
  - Reset mid-window discards all in-flight samples.
- Pipeline, fixed latency 3 cycles from din_valid to dout_valid:
  - Stage 1: register inputs.
  - Stage 2: signed squares re*re and im*im, each 2*DIN_WIDTH bits.
  - Stage 3: unsigned sum.
  - Valid bubbles propagate unchanged. No backpressure; the block accepts a sample every cycle.
- Arithmetic: the sum of squares fits in 2*DIN_WIDTH unsigned bits. The worst case (-2^(N-1), -2^(N-1)) gives 2^(2N-1), so no overflow is possible. dout is zero-extended to DOUT_WIDTH.
- Window counter (advances only on cycles where the stage-3 sample is valid):
  - The first valid output after reset asserts acc_done.
  - This makes the downstream accumulator load rather than add. The consumer discards the dump that accompanies that first acc_done.
  - acc_done is asserted when count==0; count then increments.
  - When count reaches len_r-1 it wraps to 0, so the next valid sample asserts acc_done.
- Length latching:
  - len_r latches acc_len only on a sample that asserts acc_done. A change mid-window takes effect at the next boundary.
  - acc_len=0 latches as 1, so every valid sample asserts acc_done.
- Output rules:
  - acc_done is never high while dout_valid is low.
  - dout holds its last value when dout_valid=0.
- Bubbles: invalid cycles inside a window do not advance the counter. A window is always exactly len_r valid samples.
- win_count equals the count value attached to the current dout sample (0 on acc_done).
- Simultaneous events: reset asserted while din_valid=1 has reset priority; that sample is dropped.

Decomposition:
- Shared package corr_pkg:
  - Constants for MSDFT bin width (DIN_WIDTH default) and power width.
  - Function clog2 for deriving LEN_WIDTH at integration.
- Sub-module complex_pow holds the 3-stage squaring/add pipeline (inputs din_re, din_im, din_valid; outputs pow, pow_valid) with rst.
- pow_acc_ctrl contains complex_pow plus the window counter, len_r latch and output registers.

Test Plan:
- Reset, then din_re=3, din_im=-4, din_valid=1 for one cycle -> 3 cycles later dout=25, dout_valid=1, acc_done=1, win_count=0.
- acc_len=4, 10 continuous valid samples of (1,1) -> dout=2 every cycle; acc_done on output samples 0, 4, 8; win_count sequence 0,1,2,3,0,1,2,3,0,1.
- acc_len=3 with a 2-cycle din_valid=0 bubble after sample 1 -> acc_done still on valid samples 0, 3, 6; dout_valid low during the bubble; counter frozen.
- Extreme input din_re=din_im=-32768 (DIN_WIDTH=16) -> dout=0x8000_0000; for (32767,-32768) -> dout=0x7FFF_0001; no wrap.
- acc_len changed 4->2 at mid-window sample 2 -> current window completes at 4 samples; following windows are 2 samples; acc_len=0 -> acc_done on every valid sample.
- rst=0 for 1 cycle in the middle of a window with 2 samples in flight -> those samples never appear; the next valid output asserts acc_done with win_count=0.
